sprite_motion: RTL and testbench
================================

# sprite_motion

Per-player motion stage sitting directly upstream of the sprite hit-test logic. Once per video frame it advances one player's bottom-left position from button inputs, a fixed walk speed, a jump impulse and constant gravity against a flat floor. It drives the packed 64-bit sprite descriptor `{x, y, w, h}` in y-up screen coordinates. The descriptor changes only on frame ticks, so the pixel-side hit test sees a stable value for the whole displayed frame.

## Interface
Parameters:
- `START_X`, 100: x position after reset.
- `FLOOR_Y`, 40: floor height and y position after reset; the sprite bottom never goes below it.
- `WIDTH`, 32: sprite width, emitted in `spriteData[31:16]`.
- `HEIGHT`, 48: sprite height, emitted in `spriteData[15:0]`.
- `SCREEN_W`, 640: screen width; x is clamped to `[0, SCREEN_W-WIDTH]`.
- `WALK_SPEED`, 4: horizontal pixels per frame.
- `JUMP_VEL`, 12: upward velocity applied by a jump, in pixels per frame.
- `GRAVITY`, 1: velocity decrement per frame.
- `MAX_FALL`, 10: maximum downward speed; velocity saturates at `-MAX_FALL`.

Ports:
- `clock` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse once per frame, at vblank start.
- `move_left` in 1: level; walk left while high.
- `move_right` in 1: level; walk right while high.
- `jump` in 1: level; each rising edge requests one jump.
- `spriteData` out 64: `{x[15:0], y[15:0], WIDTH[15:0], HEIGHT[15:0]}`, with y-up and the origin at the bottom-left.
- `grounded` out 1: high while in GROUND.
- `state` out 2: 0=GROUND, 1=RISE, 2=FALL.
- `updated` out 1: one-cycle pulse when a frame update commits.

## Operation
- Registers: `x` and `y` (16-bit unsigned), `vy` (16-bit signed), `state`, `jump_prev`, `jump_pending`, `air_jump_avail`.
- Jump edge detect runs every clock: `jump & ~jump_prev` sets `jump_pending`.
  - `jump_pending` clears on every `frame_tick`, whether the jump is taken or not; requests never carry across frames.
  - An edge in the same cycle as `frame_tick` counts for that tick.
  - A held level never retriggers.
- All updates below happen only in the `frame_tick` cycle.
- Horizontal:
  - `move_right` alone: `x += WALK_SPEED`.
  - `move_left` alone: `x -= WALK_SPEED`.
  - Both or neither: no change.
  - Clamp to `[0, SCREEN_W-WIDTH]`. Compute in a 17-bit signed intermediate so underflow clamps to 0, never wraps.
- Jump taken when `jump_pending` and in GROUND, or in RISE/FALL with `air_jump_avail` (see Configuration).
- Vertical:
  - `vy_eff` = jump taken ? `JUMP_VEL` : `vy`.
  - In GROUND with no jump: `y` and `vy` unchanged (0).
  - Otherwise: `y_new = y + vy_eff` (17-bit signed intermediate); `vy_new = max(vy_eff - GRAVITY, -MAX_FALL)`.
- State transitions, evaluated in this order:
  - `y_new <= FLOOR_Y` while airborne: `y=FLOOR_Y`, `vy=0`, go to GROUND, `air_jump_avail=1`.
  - Else if `vy_new <= 0`: go to FALL.
  - Else: go to RISE.
  - GROUND with a jump goes to RISE, or directly to FALL if `JUMP_VEL <= GRAVITY`.
- `updated` pulses on every `frame_tick`, even when nothing moved.
- No other inputs are consumed between ticks; `spriteData` is held.

## Timing
- Latency:
  - `frame_tick` sampled at edge N; new `spriteData`, `state`, `grounded` and `updated=1` are visible after edge N.
  - `updated` drops after edge N+1.
- Back-to-back ticks (every cycle) are legal; each is a full independent update.
- Reset values (asynchronous, immediate, including mid-air):
  - `x=START_X`, `y=FLOOR_Y`, `vy=0`.
  - `state=GROUND`, `grounded=1`, `updated=0`.
  - `jump_pending=0`, `jump_prev=0`, `air_jump_avail=1`.
  - `spriteData={START_X, FLOOR_Y, WIDTH, HEIGHT}`.
- The first tick after `resetn` rises is processed normally.

## Configuration
- `SPRITE_DOUBLE_JUMP_EN` defined:
  - In RISE/FALL with `air_jump_avail=1`, a pending jump is taken and `vy_eff=JUMP_VEL` regardless of the current `vy`.
  - `air_jump_avail` clears when the air jump is taken and is restored on landing.
- Undefined:
  - Jumps are taken only in GROUND; airborne requests are discarded.
  - `air_jump_avail` logic is absent.

## Test plan
All scenarios use default parameters.
- Reset, then release: `spriteData=64'h0064_0028_0020_0030`, `grounded=1`, `state=0`, `updated=0`. Assert `resetn` low mid-air: same values immediately, without a clock edge.
- Walking:
  - `move_right` held for 3 ticks: x=112.
  - Both buttons for 2 ticks: x=112.
  - Ticks every cycle: one `updated` pulse per tick; x changes only on tick cycles.
- Clamping:
  - At x=604, `move_right`, 2 ticks: x=608 then 608.
  - At x=2, `move_left`: x=0, no wrap.
- Jump arc: a jump pulse, then ticks:
  - Tick 1: y=52, RISE.
  - Tick 12: y=118, FALL.
  - Tick 23: y=63.
  - Tick 26: y=40, GROUND, `vy=0`.
- Held jump and request discard: hold `jump` high across the landing; no retrigger. Edge coincident with `frame_tick` is taken on that tick. An edge followed by 2 ticks gives one jump only.
- Airborne jump at y=118 (FALL):
  - Without `SPRITE_DOUBLE_JUMP_EN`: ignored, next tick y=118.
  - With it: next tick y=130, RISE; a second airborne jump is ignored until after landing.

Source files
------------

// File: rtl/sprite_motion_if.sv
// Frame-rate control and descriptor bundle between the game logic and sprite_motion.
// Handshake: frame_tick is a one-cycle strobe with no ready; updated answers each strobe one cycle later.
interface sprite_motion_if;
    logic        frame_tick;
    logic        move_left;
    logic        move_right;
    logic        jump;
    logic [63:0] spriteData;
    logic        grounded;
    logic [1:0]  state;
    logic        updated;

    modport master (
        output frame_tick, move_left, move_right, jump,
        input  spriteData, grounded, state, updated
    );

    modport slave (
        input  frame_tick, move_left, move_right, jump,
        output spriteData, grounded, state, updated
    );
endinterface

// File: rtl/sprite_motion.sv
// Per-frame player motion: walk, jump and gravity against a flat floor, emitting {x, y, w, h}.
// Optional SPRITE_DOUBLE_JUMP_EN allows one extra jump while airborne, restored on landing.
module sprite_motion #(
    parameter int START_X    = 100,
    parameter int FLOOR_Y    = 40,
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 48,
    parameter int SCREEN_W   = 640,
    parameter int WALK_SPEED = 4,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 10
) (
    input logic            clock,
    input logic            resetn,
    sprite_motion_if.slave bus
);
    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    localparam logic signed [16:0] X_MAX    = 17'(SCREEN_W - WIDTH);
    localparam logic signed [16:0] FLOOR    = 17'(FLOOR_Y);
    localparam logic signed [16:0] STEP_R   = 17'(WALK_SPEED);
    localparam logic signed [16:0] STEP_L   = 17'(-WALK_SPEED);
    localparam logic signed [15:0] JUMP_V   = 16'(JUMP_VEL);
    localparam logic signed [15:0] GRAV     = 16'(GRAVITY);
    localparam logic signed [15:0] FALL_MIN = 16'(-MAX_FALL);

    state_t             state_q, state_n;
    logic        [15:0] x_q, x_n, y_q, y_n;
    logic signed [15:0] vy_q, vy_n;
    logic               jump_prev_q, jump_pending_q, jump_pending_n;
    logic               updated_q;
`ifdef SPRITE_DOUBLE_JUMP_EN
    logic               air_jump_avail_q, air_jump_avail_n;
`endif

    logic               pending, take_jump, airborne;
    logic signed [16:0] dx, x_sum, y_sum;
    logic signed [15:0] vy_eff, vy_dec, vy_new;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= GROUND;
        else         state_q <= state_n;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q            <= 16'(START_X);
            y_q            <= 16'(FLOOR_Y);
            vy_q           <= '0;
            jump_prev_q    <= 1'b0;
            jump_pending_q <= 1'b0;
            updated_q      <= 1'b0;
`ifdef SPRITE_DOUBLE_JUMP_EN
            air_jump_avail_q <= 1'b1;
`endif
        end else begin
            x_q            <= x_n;
            y_q            <= y_n;
            vy_q           <= vy_n;
            jump_prev_q    <= bus.jump;
            jump_pending_q <= jump_pending_n;
            updated_q      <= bus.frame_tick;
`ifdef SPRITE_DOUBLE_JUMP_EN
            air_jump_avail_q <= air_jump_avail_n;
`endif
        end
    end

    // An edge arriving in the tick cycle itself still counts for that tick.
    always_comb begin
        pending  = jump_pending_q | (bus.jump & ~jump_prev_q);
        airborne = (state_q != GROUND);
`ifdef SPRITE_DOUBLE_JUMP_EN
        take_jump = pending & (!airborne | air_jump_avail_q);
`else
        take_jump = pending & !airborne;
`endif
        if (bus.move_right && !bus.move_left)      dx = STEP_R;
        else if (bus.move_left && !bus.move_right) dx = STEP_L;
        else                                       dx = '0;
        x_sum  = $signed({1'b0, x_q}) + dx;
        vy_eff = take_jump ? JUMP_V : vy_q;
        y_sum  = $signed({1'b0, y_q}) + 17'(vy_eff);
        vy_dec = vy_eff - GRAV;
        vy_new = (vy_dec < FALL_MIN) ? FALL_MIN : vy_dec;

        state_n        = state_q;
        x_n            = x_q;
        y_n            = y_q;
        vy_n           = vy_q;
        jump_pending_n = pending;
`ifdef SPRITE_DOUBLE_JUMP_EN
        air_jump_avail_n = air_jump_avail_q;
`endif
        if (bus.frame_tick) begin
            jump_pending_n = 1'b0;
            if (x_sum < 0)          x_n = '0;
            else if (x_sum > X_MAX) x_n = X_MAX[15:0];
            else                    x_n = x_sum[15:0];

            if (airborne && y_sum <= FLOOR) begin
                y_n     = FLOOR[15:0];
                vy_n    = '0;
                state_n = GROUND;
`ifdef SPRITE_DOUBLE_JUMP_EN
                air_jump_avail_n = 1'b1;
`endif
            end else if (airborne || take_jump) begin
                y_n     = y_sum[15:0];
                vy_n    = vy_new;
                state_n = (vy_new <= 0) ? FALL : RISE;
`ifdef SPRITE_DOUBLE_JUMP_EN
                if (airborne && take_jump) air_jump_avail_n = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        bus.spriteData = {x_q, y_q, 16'(WIDTH), 16'(HEIGHT)};
        bus.grounded   = (state_q == GROUND);
        bus.state      = state_q;
        bus.updated    = updated_q;
    end
endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: reset, walking, clamping, jump arc, jump edge rules, mid-air reset.
module tb_sprite_motion;
    logic clock = 1'b0;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    sprite_motion_if bus ();

    sprite_motion dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic jump_pulse();
        bus.jump = 1'b1;
        step();
        bus.jump = 1'b0;
    endtask

    task automatic land(input string tag);
        for (int i = 0; i < 100 && bus.grounded !== 1'b1; i++) tick();
        check({tag, "_grounded"}, 64'(bus.grounded), 64'd1);
        check({tag, "_y"}, 64'(bus.spriteData[47:32]), 64'd40);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        bus.jump       = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        check("reset_sprite", bus.spriteData, 64'h0064_0028_0020_0030);
        check("reset_grounded", 64'(bus.grounded), 64'd1);
        check("reset_state", 64'(bus.state), 64'd0);
        check("reset_updated", 64'(bus.updated), 64'd0);

        // walking
        bus.move_right = 1'b1;
        tick(); check("walk_x1", 64'(bus.spriteData[63:48]), 64'd104);
        check("walk_upd", 64'(bus.updated), 64'd1);
        tick(); check("walk_x2", 64'(bus.spriteData[63:48]), 64'd108);
        tick(); check("walk_x3", 64'(bus.spriteData[63:48]), 64'd112);
        step(); check("upd_drop", 64'(bus.updated), 64'd0);
        bus.move_left = 1'b1;
        tick(); tick();
        check("both_x", 64'(bus.spriteData[63:48]), 64'd112);
        bus.move_left = 1'b0;

        // back-to-back ticks
        bus.frame_tick = 1'b1;
        step(); check("b2b_x1", 64'(bus.spriteData[63:48]), 64'd116);
        check("b2b_upd1", 64'(bus.updated), 64'd1);
        step(); check("b2b_x2", 64'(bus.spriteData[63:48]), 64'd120);
        check("b2b_upd2", 64'(bus.updated), 64'd1);
        bus.frame_tick = 1'b0;
        step(); check("b2b_upd3", 64'(bus.updated), 64'd0);
        check("b2b_hold1", 64'(bus.spriteData[63:48]), 64'd120);
        step(); check("b2b_hold2", 64'(bus.spriteData[63:48]), 64'd120);

        // right clamp
        repeat (121) tick();
        check("clamp_r0", 64'(bus.spriteData[63:48]), 64'd604);
        tick(); check("clamp_r1", 64'(bus.spriteData[63:48]), 64'd608);
        tick(); check("clamp_r2", 64'(bus.spriteData[63:48]), 64'd608);
        bus.move_right = 1'b0;

        // left clamp
        bus.move_left = 1'b1;
        repeat (151) tick();
        check("clamp_l0", 64'(bus.spriteData[63:48]), 64'd4);
        tick(); check("clamp_l1", 64'(bus.spriteData[63:48]), 64'd0);
        tick(); check("clamp_l2", 64'(bus.spriteData[63:48]), 64'd0);
        bus.move_left = 1'b0;

        // jump arc
        jump_pulse();
        tick();
        check("arc1_y", 64'(bus.spriteData[47:32]), 64'd52);
        check("arc1_state", 64'(bus.state), 64'd1);
        check("arc1_grounded", 64'(bus.grounded), 64'd0);
        repeat (11) tick();
        check("arc12_y", 64'(bus.spriteData[47:32]), 64'd118);
        check("arc12_state", 64'(bus.state), 64'd2);
        repeat (11) tick();
        check("arc23_y", 64'(bus.spriteData[47:32]), 64'd63);
        repeat (2) tick();
        check("arc25_y", 64'(bus.spriteData[47:32]), 64'd43);
        tick();
        check("arc26_y", 64'(bus.spriteData[47:32]), 64'd40);
        check("arc26_state", 64'(bus.state), 64'd0);
        tick();
        check("arc27_rest", 64'(bus.spriteData[47:32]), 64'd40);
        check("arc27_state", 64'(bus.state), 64'd0);

        // held jump across landing does not retrigger
        bus.jump = 1'b1;
        step();
        repeat (26) tick();
        check("held_land", 64'(bus.spriteData[47:32]), 64'd40);
        tick(); tick();
        check("held_noretrig_y", 64'(bus.spriteData[47:32]), 64'd40);
        check("held_noretrig_st", 64'(bus.state), 64'd0);
        bus.jump = 1'b0;
        step();

        // edge coincident with tick
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
        check("coinc_y", 64'(bus.spriteData[47:32]), 64'd52);
        check("coinc_state", 64'(bus.state), 64'd1);
        land("coinc");

        // one edge, two ticks: only one jump
        jump_pulse();
        tick(); tick();
        check("one_jump_y", 64'(bus.spriteData[47:32]), 64'd63);
        land("one_jump");

        // airborne request at the apex
        jump_pulse();
        repeat (12) tick();
        check("apex_y", 64'(bus.spriteData[47:32]), 64'd118);
        jump_pulse();
        tick();
`ifdef SPRITE_DOUBLE_JUMP_EN
        check("air_jump_y", 64'(bus.spriteData[47:32]), 64'd130);
        check("air_jump_state", 64'(bus.state), 64'd1);
        jump_pulse();
        tick();
        check("air_jump2_y", 64'(bus.spriteData[47:32]), 64'd141);
`else
        check("air_ignore_y", 64'(bus.spriteData[47:32]), 64'd118);
        check("air_ignore_state", 64'(bus.state), 64'd2);
        tick();
        check("air_nocarry_y", 64'(bus.spriteData[47:32]), 64'd117);
`endif
        land("air");

        // asynchronous reset mid-air
        bus.move_right = 1'b1;
        jump_pulse();
        repeat (3) tick();
        check("mid_y", 64'(bus.spriteData[47:32]), 64'd73);
        check("mid_state", 64'(bus.state), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_sprite", bus.spriteData, 64'h0064_0028_0020_0030);
        check("async_grounded", 64'(bus.grounded), 64'd1);
        check("async_state", 64'(bus.state), 64'd0);
        check("async_updated", 64'(bus.updated), 64'd0);
        step();
        resetn = 1'b1;
        tick();
        check("post_reset_x", 64'(bus.spriteData[63:48]), 64'd104);
        check("post_reset_upd", 64'(bus.updated), 64'd1);
        check("post_reset_y", 64'(bus.spriteData[47:32]), 64'd40);
        bus.move_right = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
